// File: rtl/tmr_recovery_ctrl.sv
// Fault-recovery sequencer for the triple-redundant core cluster.
// It filters voter mismatches, then holds, resyncs and resumes the cores, and retires a core after repeated faults.
module tmr_recovery_ctrl #(
    parameter int FILTER_CYCLES = 2,
    parameter int HOLD_CYCLES   = 4,
    parameter int RESYNC_CYCLES = 8,
    parameter int MAX_FAULTS    = 3,
    parameter int CNT_W         = 4
) (
    input  logic               clk,
    input  logic               main_rst,
    input  logic [2:0]         voter_state,
    output logic               core_hold,
    output logic [2:0]         core_rst,
    output logic [2:0]         core_disable,
    output logic [1:0]         fault_core,
    output logic [3*CNT_W-1:0] fault_cnt,
    output logic               busy,
    output logic               fatal
);

    localparam int TMAX = (HOLD_CYCLES > RESYNC_CYCLES) ? HOLD_CYCLES : RESYNC_CYCLES;
    localparam int TW   = $clog2(TMAX + 1);
    localparam int FW   = $clog2(FILTER_CYCLES + 1);

    localparam logic [FW-1:0]    FILT_MAX = FW'(FILTER_CYCLES);
    localparam logic [TW-1:0]    H_LAST   = TW'(HOLD_CYCLES - 1);
    localparam logic [TW-1:0]    R_LAST   = TW'(RESYNC_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_LIM  = CNT_W'(MAX_FAULTS);

    typedef enum logic [2:0] {
        MONITOR,
        SUSPECT,
        HOLD,
        RESYNC,
        FATAL
    } state_t;

    state_t                  state, state_d;
    logic [FW-1:0]           filt, filt_d;
    logic [TW-1:0]           tmr, tmr_d;
    logic [1:0]              fc_d;
    logic [2:0][CNT_W-1:0]   cnt, cnt_d;
    logic [2:0]              dis_d, rst_d, m;
    logic                    multi, single, go_fatal, hold_d;
    logic [1:0]              idx;

    always_comb begin
        state_d  = state;
        filt_d   = filt;
        tmr_d    = tmr;
        fc_d     = fault_core;
        cnt_d    = cnt;
        dis_d    = core_disable;
        rst_d    = 3'b000;
        hold_d   = 1'b0;

        // A retired core's disagreement is meaningless, so it is masked out.
        m        = voter_state & ~core_disable;
        multi    = (m[0] & m[1]) | (m[0] & m[2]) | (m[1] & m[2]);
        single   = (m != 3'b000) && !multi;
        go_fatal = (voter_state == 3'b111) || multi
                   || ((m != 3'b000) && (core_disable != 3'b000));
        idx      = m[0] ? 2'd0 : (m[1] ? 2'd1 : 2'd2);

        unique case (state)
            MONITOR: begin
                if (go_fatal) begin
                    state_d = FATAL;
                end else if (single) begin
                    fc_d    = idx;
                    filt_d  = FW'(1);
                    state_d = (FILTER_CYCLES == 1) ? HOLD : SUSPECT;
                end
            end
            SUSPECT: begin
                if (go_fatal) begin
                    state_d = FATAL;
                end else if (m == 3'b000) begin
                    state_d = MONITOR;
                end else if (idx != fault_core) begin
                    fc_d   = idx;
                    filt_d = FW'(1);
                end else if (filt + FW'(1) == FILT_MAX) begin
                    filt_d  = FILT_MAX;
                    state_d = HOLD;
                end else begin
                    filt_d = filt + FW'(1);
                end
            end
            HOLD: begin
                if (tmr == H_LAST) begin
                    tmr_d   = '0;
                    state_d = RESYNC;
                end else begin
                    tmr_d = tmr + TW'(1);
                end
            end
            RESYNC: begin
                if (tmr == R_LAST) begin
                    tmr_d   = '0;
                    state_d = MONITOR;
                    for (int i = 0; i < 3; i++)
                        if (fault_core == 2'(i) && cnt[i] >= CNT_LIM)
                            dis_d[i] = 1'b1;
                end else begin
                    tmr_d = tmr + TW'(1);
                end
            end
            FATAL: state_d = FATAL;
            default: state_d = MONITOR;
        endcase

        // Fault is charged once, on the edge that freezes the cluster.
        if (state_d == HOLD && state != HOLD) begin
            tmr_d = '0;
            for (int i = 0; i < 3; i++)
                if (fc_d == 2'(i) && cnt[i] != '1)
                    cnt_d[i] = cnt[i] + CNT_W'(1);
        end

        hold_d = (state_d == HOLD) || (state_d == RESYNC) || (state_d == FATAL);
        rst_d  = dis_d;
        if (state_d == RESYNC)
            for (int i = 0; i < 3; i++)
                if (fc_d == 2'(i))
                    rst_d[i] = 1'b1;
        if (state_d == FATAL)
            rst_d = 3'b111;
    end

    always_ff @(posedge clk or posedge main_rst) begin
        if (main_rst) begin
            state        <= MONITOR;
            filt         <= '0;
            tmr          <= '0;
            fault_core   <= 2'd0;
            cnt          <= '0;
            core_disable <= 3'b000;
            core_rst     <= 3'b000;
            core_hold    <= 1'b0;
            busy         <= 1'b0;
            fatal        <= 1'b0;
        end else begin
            state        <= state_d;
            filt         <= filt_d;
            tmr          <= tmr_d;
            fault_core   <= fc_d;
            cnt          <= cnt_d;
            core_disable <= dis_d;
            core_rst     <= rst_d;
            core_hold    <= hold_d;
            busy         <= (state_d != MONITOR);
            fatal        <= (state_d == FATAL);
        end
    end

    assign fault_cnt = cnt;

endmodule

// File: tb/tb_tmr_recovery_ctrl.sv
// Scoreboard bench for tmr_recovery_ctrl: expected outputs are queued per driven cycle.
// They are compared on the falling edge after the sampling edge.
module tb_tmr_recovery_ctrl;

    localparam int CW = 4;

    logic          clk = 1'b0;
    logic          main_rst;
    logic [2:0]    voter_state;
    logic          core_hold;
    logic [2:0]    core_rst;
    logic [2:0]    core_disable;
    logic [1:0]    fault_core;
    logic [3*CW-1:0] fault_cnt;
    logic          busy;
    logic          fatal;

    typedef struct packed {
        logic          hold;
        logic [2:0]    rst;
        logic [2:0]    dis;
        logic [1:0]    fc;
        logic [3*CW-1:0] cnt;
        logic          busy;
        logic          fatal;
    } exp_t;

    exp_t e;
    exp_t x;
    exp_t q[$];
    int   nchk = 0;
    int   nerr = 0;

    tmr_recovery_ctrl #(
        .FILTER_CYCLES(2),
        .HOLD_CYCLES  (4),
        .RESYNC_CYCLES(8),
        .MAX_FAULTS   (3),
        .CNT_W        (CW)
    ) dut (
        .clk         (clk),
        .main_rst    (main_rst),
        .voter_state (voter_state),
        .core_hold   (core_hold),
        .core_rst    (core_rst),
        .core_disable(core_disable),
        .fault_core  (fault_core),
        .fault_cnt   (fault_cnt),
        .busy        (busy),
        .fatal       (fatal)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nchk++;
        if (obs !== exp) begin
            nerr++;
            $display("FAIL %s @%0t: got %0h, expected %0h", tag, $time, obs, exp);
        end
    endtask

    task automatic cmp_all(input string tag, input exp_t r);
        chk({tag, ".hold"},  32'(core_hold),    32'(r.hold));
        chk({tag, ".rst"},   32'(core_rst),     32'(r.rst));
        chk({tag, ".dis"},   32'(core_disable), 32'(r.dis));
        chk({tag, ".fc"},    32'(fault_core),   32'(r.fc));
        chk({tag, ".cnt"},   32'(fault_cnt),    32'(r.cnt));
        chk({tag, ".busy"},  32'(busy),         32'(r.busy));
        chk({tag, ".fatal"}, 32'(fatal),        32'(r.fatal));
    endtask

    always @(negedge clk) begin
        if (q.size() > 0) begin
            x = q.pop_front();
            cmp_all("sb", x);
        end
    end

    // Drive one sample, queue what must appear after the next rising edge.
    task automatic step(input logic [2:0] vs);
        voter_state = vs;
        q.push_back(e);
        @(posedge clk);
        #6;
    endtask

    task automatic pulse_reset(input string tag);
        main_rst = 1'b1;
        #1;
        e = '0;
        cmp_all(tag, e);
        @(posedge clk);
        #6;
        main_rst = 1'b0;
    endtask

    // Full recovery of core c with F=2, H=4, R=8 and MAX_FAULTS=3.
    task automatic recover(input int c);
        logic [2:0] oh;
        oh = 3'b001 << c;
        e.busy = 1'b1;
        e.fc   = 2'(c);
        step(oh);
        e.hold = 1'b1;
        e.cnt[c*CW +: CW] = e.cnt[c*CW +: CW] + 4'd1;
        step(oh);
        repeat (3) step(3'($urandom));
        e.rst = e.dis | oh;
        repeat (8) step(3'($urandom));
        e.hold = 1'b0;
        e.busy = 1'b0;
        if (e.cnt[c*CW +: CW] >= 4'd3)
            e.dis = e.dis | oh;
        e.rst = e.dis;
        step(3'($urandom));
    endtask

    initial begin
        main_rst    = 1'b1;
        voter_state = 3'b000;
        e           = '0;
        #12;
        cmp_all("reset", e);
        @(posedge clk);
        #6;
        main_rst = 1'b0;

        repeat (50) step(3'b000);

        // Single-cycle glitch on B is filtered out.
        e.busy = 1'b1;
        e.fc   = 2'd1;
        step(3'b010);
        e.busy = 1'b0;
        repeat (4) step(3'b000);

        recover(0);
        repeat (3) step(3'b000);

        // Suspect A, then B takes over the filter and gets recovered.
        e.busy = 1'b1;
        e.fc   = 2'd0;
        step(3'b001);
        recover(1);
        repeat (3) step(3'b000);

        for (int k = 0; k < 3; k++) begin
            recover(2);
            repeat (3) step(3'b000);
        end

        // C retired: its mismatch is now ignored.
        repeat (5) step(3'b100);

        // Degraded mode: any live mismatch has no majority.
        e.busy  = 1'b1;
        e.hold  = 1'b1;
        e.rst   = 3'b111;
        e.fatal = 1'b1;
        step(3'b001);
        repeat (6) step(3'($urandom));
        pulse_reset("rst_fatal");
        repeat (3) step(3'b000);

        e.busy  = 1'b1;
        e.hold  = 1'b1;
        e.rst   = 3'b111;
        e.fatal = 1'b1;
        step(3'b111);
        step(3'b000);
        pulse_reset("rst_nomaj");

        e.busy  = 1'b1;
        e.hold  = 1'b1;
        e.rst   = 3'b111;
        e.fatal = 1'b1;
        step(3'b011);
        step(3'b000);
        pulse_reset("rst_multi");
        repeat (2) step(3'b000);

        // Async reset in the middle of HOLD.
        e.busy = 1'b1;
        e.fc   = 2'd1;
        step(3'b010);
        e.hold = 1'b1;
        e.cnt[CW +: CW] = 4'd1;
        step(3'b010);
        step(3'b000);
        pulse_reset("rst_hold");
        repeat (3) step(3'b000);

        $display("Simulation finished: %0d checks, %0d errors", nchk, nerr);
        $finish;
    end

endmodule

// File: doc/tmr_recovery_ctrl.md
# tmr_recovery_ctrl

Fault-recovery sequencer for the triple-redundant RISC-V core cluster. Monitors the per-cycle disagreement flags from the voter, filters transient mismatches, then halts all three cores, resynchronises the faulty core by holding it in reset, and resumes. It tracks per-core fault counts, retires a core after repeated faults (degraded two-core mode), and raises a sticky fatal flag when no majority exists. It replaces the purely combinational hold path between the voter and the reset controller.

## Interface
- FILTER_CYCLES, 2, consecutive identical mismatch samples needed before recovery starts (≥1)
- HOLD_CYCLES, 4, cycles all cores are frozen before resync (≥1)
- RESYNC_CYCLES, 8, cycles the faulty core's reset is asserted (≥1)
- MAX_FAULTS, 3, fault count at which a core is permanently disabled (≥1, < 2^CNT_W)
- CNT_W, 4, width of each per-core fault counter
- clk  in  1  system clock, all state updates on rising edge
- main_rst  in  1  asynchronous, active-high reset
- voter_state  in  3  bit i set = core i (0=A,1=B,2=C) disagrees with majority; 3'b111 = no majority
- core_hold  out  1  freeze all cores (feeds reset controller)
- core_rst  out  3  per-core resync reset, active-high
- core_disable  out  3  sticky per-core retirement flags
- fault_core  out  2  index of core currently/last recovered (0..2)
- fault_cnt  out  3*CNT_W  per-core fault counters, core A in LSBs
- busy  out  1  high in any state except MONITOR
- fatal  out  1  sticky unrecoverable-fault flag

## Operation
- States: MONITOR, SUSPECT, HOLD, RESYNC, FATAL. Reset → MONITOR.
- Effective mismatch m = voter_state with disabled cores' bits masked to 0.
- MONITOR: m==0 → stay. popcount(m)≥2, or voter_state==3'b111, or any nonzero m while a core is disabled (degraded mode has no majority) → FATAL. Single bit i set → latch fault_core=i, filt_cnt=1; if FILTER_CYCLES==1 go HOLD, else SUSPECT.
- SUSPECT: same single bit i → filt_cnt+1; on reaching FILTER_CYCLES → HOLD. m==0 → MONITOR (transient, no count). Different single bit → restart filter with new core, filt_cnt=1. FATAL conditions as in MONITOR.
- HOLD entry: fault_cnt[fault_core] increments, saturating at 2^CNT_W−1. Stay HOLD_CYCLES cycles, then RESYNC. voter_state ignored.
- RESYNC: core_rst[fault_core]=1 for RESYNC_CYCLES cycles, then MONITOR. On exit, if fault_cnt[fault_core] ≥ MAX_FAULTS, set core_disable[fault_core]. voter_state ignored.
- FATAL: absorbing until main_rst; core_hold=1, fatal=1, core_rst=3'b111.
- core_rst[i]=1 permanently once core_disable[i]=1.
- A second core reaching disable is impossible: degraded-mode mismatch goes FATAL first.

## Timing
- All outputs registered; reset values: core_hold=0, core_rst=0, core_disable=0, fault_core=0, fault_cnt=0, busy=0, fatal=0.
- voter_state sampled at each rising edge; output effects visible the cycle after the sampling edge.
- Detection latency (FILTER_CYCLES=F): first mismatch sampled at edge k → core_hold high after edge k+F−1.
- core_hold high for exactly HOLD_CYCLES+RESYNC_CYCLES cycles per recovery; core_rst[i] high during the last RESYNC_CYCLES of them; both drop on the same edge.
- busy = (state != MONITOR), same timing as state register.
- main_rst assertion mid-recovery: all outputs to reset values immediately (async), including counters and disable flags.

## Test plan
- Reset then voter_state=0 for 50 cycles → busy=0, core_hold=0, all counters 0.
- voter_state=3'b010 for 1 cycle only (F=2) → enters SUSPECT, returns MONITOR, core_hold never asserted, fault_cnt B=0.
- voter_state=3'b001 held → core_hold high 2 cycles after first sample, high 12 cycles, core_rst=3'b001 during last 8, fault_cnt A=1, fault_core=0.
- Three recoveries of core C → after third RESYNC core_disable=3'b100, core_rst[2] stays 1; later voter_state=3'b100 ignored.
- In degraded mode (C disabled) voter_state=3'b001 → FATAL, fatal=1, core_hold=1, core_rst=3'b111 until main_rst.
- voter_state=3'b111 in MONITOR → FATAL next cycle; main_rst asserted mid-HOLD → outputs clear without waiting for clk.
